// File: rtl/booth_divider_seq_if.sv
// Handshake and result bundle for the sequential signed divider.
// The requester drives start and the operands; the divider returns status and results.
interface booth_divider_seq_if #(
    parameter int N   = 4,
    parameter int CCW = 8
);
    logic           start;
    logic [N-1:0]   dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;
    logic [CCW-1:0] clock_count;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow, clock_count
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow, clock_count
    );
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per clock, followed by a sign fix-up cycle.
module booth_divider_seq #(
    parameter int N   = 4,
    parameter int CCW = 8
) (
    input logic               clk,
    input logic               rst_n,
    booth_divider_seq_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement negation kept to N bits; |-2^(N-1)| lands as an unsigned 2^(N-1).
    function automatic logic [N-1:0] neg_f(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [N-1:0] abs_f(input logic [N-1:0] v);
        logic [N-1:0] m;
        if (v[N-1]) begin
            m = neg_f(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t         state_q, state_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   d_q, d_d;
    logic [N-1:0]   qm_q, qm_d;
    logic [CW-1:0]  iter_q, iter_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic           dz_q, dz_d;
    logic           ov_q, ov_d;
    logic           done_q, done_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dzo_q, dzo_d;
    logic           ovo_q, ovo_d;
    logic [CCW-1:0] cnt_q, cnt_d;
    logic [N:0]     r_sh_s;
    logic [N-1:0]   rem_src_s;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= {N{1'b0}};
            d_q     <= {N{1'b0}};
            qm_q    <= {N{1'b0}};
            iter_q  <= {CW{1'b0}};
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= {N{1'b0}};
            rem_q   <= {N{1'b0}};
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
            cnt_q   <= {CCW{1'b0}};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            d_q     <= d_d;
            qm_q    <= qm_d;
            iter_q  <= iter_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
            ovo_q   <= ovo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, one restoring step per DIV cycle, and result fix-up.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        d_d       = d_q;
        qm_d      = qm_q;
        iter_d    = iter_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        dz_d      = dz_q;
        ov_d      = ov_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dzo_d     = dzo_q;
        ovo_d     = ovo_q;
        cnt_d     = cnt_q;
        r_sh_s    = {r_q, qm_q[N-1]};
        rem_src_s = r_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    qm_d   = abs_f(bus.dividend);
                    d_d    = abs_f(bus.divisor);
                    r_d    = {N{1'b0}};
                    sa_d   = bus.dividend[N-1];
                    sb_d   = bus.divisor[N-1];
                    dz_d   = (bus.divisor == {N{1'b0}});
                    ov_d   = (bus.dividend == {1'b1, {(N-1){1'b0}}}) &&
                             (bus.divisor == {N{1'b1}});
                    dzo_d  = 1'b0;
                    ovo_d  = 1'b0;
                    iter_d = {CW{1'b0}};
                    cnt_d  = {{(CCW-1){1'b0}}, 1'b1};
                    if (bus.divisor == {N{1'b0}}) begin
                        state_d = FIX;
                    end else begin
                        state_d = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                // R stays below D <= 2^(N-1), so the shifted value needs only N+1 bits.
                qm_d = {qm_q[N-2:0], 1'b0};
                if (r_sh_s >= {1'b0, d_q}) begin
                    r_d     = r_sh_s[N-1:0] - d_q;
                    qm_d[0] = 1'b1;
                end else begin
                    r_d = r_sh_s[N-1:0];
                end
                iter_d = iter_q + {{(CW-1){1'b0}}, 1'b1};
                cnt_d  = cnt_q + {{(CCW-1){1'b0}}, 1'b1};
                if (iter_q == CW'(N - 1)) begin
                    state_d = FIX;
                end else begin
                    state_d = DIV;
                end
            end
            FIX: begin
                // On divide-by-zero qm still holds |dividend|, which restores the dividend.
                if (dz_q) begin
                    rem_src_s = qm_q;
                    quo_d     = {N{1'b1}};
                end else begin
                    rem_src_s = r_q;
                    if (sa_q ^ sb_q) begin
                        quo_d = neg_f(qm_q);
                    end else begin
                        quo_d = qm_q;
                    end
                end
                if (sa_q) begin
                    rem_d = neg_f(rem_src_s);
                end else begin
                    rem_d = rem_src_s;
                end
                dzo_d   = dz_q;
                ovo_d   = ov_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dzo_q;
    assign bus.overflow    = ovo_q;
    assign bus.clock_count = cnt_q;
endmodule

// File: tb/tb_booth_divider_seq.sv
// Self-checking bench for booth_divider_seq at N=4: directed cases, busy/back-to-back
// behaviour, mid-operation reset, exhaustive sweep and random back-to-back traffic.
module tb_booth_divider_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    booth_divider_seq_if #(.N(4), .CCW(8)) bus ();

    booth_divider_seq #(.N(4), .CCW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating signed division with the divide-by-zero and overflow special cases.
    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic dz, output logic ov);
        int ai;
        int bi;
        ai = $signed(a);
        bi = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q  = 4'hF;
            r  = a;
            dz = 1'b1;
        end else if (ai == -8 && bi == -1) begin
            q  = 4'h8;
            r  = 4'h0;
            ov = 1'b1;
        end else begin
            q = 4'(ai / bi);
            r = 4'(ai % bi);
        end
    endfunction

    // Launch one operation from the current cycle and wait (bounded) for done.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         output int edges, output logic busy_e0);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges   = 1;
        busy_e0 = bus.busy;
        while (!bus.done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] a, input logic [3:0] b,
                                input int edges);
        logic [3:0] eq, er;
        logic       edz, eov;
        int         elat;
        model(a, b, eq, er, edz, eov);
        elat = (b == 4'h0) ? 2 : 6;
        n_cmp++;
        if (edges !== elat) begin
            $display("FAIL %s latency a=%h b=%h got=%0d exp=%0d", tag, a, b, edges, elat);
            n_err++;
        end
        n_cmp++;
        if (bus.quotient !== eq) begin
            $display("FAIL %s quotient a=%h b=%h got=%h exp=%h", tag, a, b, bus.quotient, eq);
            n_err++;
        end
        n_cmp++;
        if (bus.remainder !== er) begin
            $display("FAIL %s remainder a=%h b=%h got=%h exp=%h", tag, a, b, bus.remainder, er);
            n_err++;
        end
        n_cmp++;
        if ({bus.div_by_zero, bus.overflow} !== {edz, eov}) begin
            $display("FAIL %s flags a=%h b=%h got=%b%b exp=%b%b", tag, a, b,
                     bus.div_by_zero, bus.overflow, edz, eov);
            n_err++;
        end
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = 4'h0;
        bus.divisor  = 4'h0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
             bus.overflow, bus.clock_count} !== 20'h0) begin
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b ov=%b cc=%0d exp all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
                     bus.overflow, bus.clock_count);
            n_err++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [3:0] ta [7] = '{4'd7, 4'b1001, 4'd7, 4'b1010, 4'd5, 4'b1000, 4'b1000};
        logic [3:0] tb [7] = '{4'd2, 4'd2, 4'b1110, 4'b1101, 4'd0, 4'b1111, 4'd1};
        logic [3:0] tq [7] = '{4'b0011, 4'b1101, 4'b1101, 4'b0010, 4'b1111, 4'b1000, 4'b1000};
        logic [3:0] tr [7] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000};
        logic [1:0] tf [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
        int   edges;
        logic busy_e0;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], edges, busy_e0);
            n_cmp++;
            if (edges !== ((tb[i] == 4'h0) ? 2 : 6)) begin
                $display("FAIL dir_latency case=%0d got=%0d", i, edges);
                n_err++;
            end
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !==
                {tq[i], tr[i], tf[i]}) begin
                $display("FAIL dir_result case=%0d got q=%h r=%h dz=%b ov=%b exp q=%h r=%h f=%b",
                         i, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                         tq[i], tr[i], tf[i]);
                n_err++;
            end
            n_cmp++;
            if ({busy_e0, bus.busy} !== 2'b10) begin
                $display("FAIL dir_busy case=%0d got e0=%b done=%b exp 1 then 0", i, busy_e0, bus.busy);
                n_err++;
            end
            n_cmp++;
            if (bus.clock_count !== ((tb[i] == 4'h0) ? 8'd1 : 8'd5)) begin
                $display("FAIL dir_count case=%0d got=%0d", i, bus.clock_count);
                n_err++;
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.done, bus.quotient, bus.remainder} !== {1'b0, tq[i], tr[i]}) begin
                $display("FAIL dir_hold case=%0d got done=%b q=%h r=%h exp done=0 q=%h r=%h",
                         i, bus.done, bus.quotient, bus.remainder, tq[i], tr[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_busy_ignore();
        int   edges;
        logic busy_e0;
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        @(posedge clk); #1;
        edges = 1;
        while (!bus.done && edges < 20) begin
            bus.start = (edges == 2);
            if (edges == 2) begin
                bus.dividend = 4'd3;
                bus.divisor  = 4'd1;
            end else begin
                bus.dividend = 4'd7;
                bus.divisor  = 4'd2;
            end
            @(posedge clk); #1;
            edges++;
        end
        bus.start = 1'b0;
        check_result("ignore", 4'd7, 4'd2, edges);
        do_op(4'd3, 4'd1, edges, busy_e0);
        n_cmp++;
        if (busy_e0 !== 1'b1) begin
            $display("FAIL done_cycle_start busy got=%b exp=1", busy_e0);
            n_err++;
        end
        check_result("done_cycle", 4'd3, 4'd1, edges);
    endtask

    task automatic test_reset_mid();
        int edges;
        logic busy_e0;
        int done_seen;
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
             bus.overflow, bus.clock_count} !== 20'h0) begin
            $display("FAIL mid_reset got busy=%b q=%h r=%h cc=%0d exp all 0",
                     bus.busy, bus.quotient, bus.remainder, bus.clock_count);
            n_err++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin
            $display("FAIL mid_reset_nodone got=%0d active cycles exp=0", done_seen);
            n_err++;
        end
        do_op(4'd6, 4'd4, edges, busy_e0);
        check_result("after_reset", 4'd6, 4'd4, edges);
    endtask

    task automatic test_exhaustive();
        int   edges;
        logic busy_e0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(4'(a), 4'(b), edges, busy_e0);
                check_result("sweep", 4'(a), 4'(b), edges);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         edges;
        logic       busy_e0;
        logic [3:0] a;
        logic [3:0] b;
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            do_op(a, b, edges, busy_e0);
            check_result("random", a, b, edges);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_exhaustive();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
